// File: rtl/multi_channel_timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
//   Shared definitions for multi_channel_timer and its channel sub-module.
//   - tmr_mode_e : per-channel bound behaviour (saturate / wrap)
//   - slice_lo   : low bit index of a channel's slice in a packed bus
// ---------------------------------------------------------------------------
package timer_pkg;

   typedef enum logic {
      TMR_SAT  = 1'b0,
      TMR_WRAP = 1'b1
   } tmr_mode_e;

   function automatic int unsigned slice_lo(input int unsigned ch,
                                            input int unsigned width);
      return ch * width;
   endfunction

endpackage

// File: rtl/multi_channel_timer_if.sv
// ---------------------------------------------------------------------------
// multi_channel_timer_if
//   Request/status bundle for multi_channel_timer. Per-channel vectors carry
//   one bit per channel; value buses carry channel i in
//   [i*BIT_WIDTH +: BIT_WIDTH].
//   master : drives ch_up/ch_down/ch_load/ch_load_max/ch_wrap/load_val/max_val,
//            observes count/at_zero/at_max/tc_pulse
//   slave  : the timer itself (opposite directions)
// ---------------------------------------------------------------------------
interface multi_channel_timer_if #(
   parameter int unsigned BIT_WIDTH = 5,
   parameter int unsigned NUM_CH    = 4
);

   logic [NUM_CH-1:0]           ch_up;
   logic [NUM_CH-1:0]           ch_down;
   logic [NUM_CH-1:0]           ch_load;
   logic [NUM_CH-1:0]           ch_load_max;
   logic [NUM_CH-1:0]           ch_wrap;
   logic [NUM_CH*BIT_WIDTH-1:0] load_val;
   logic [NUM_CH*BIT_WIDTH-1:0] max_val;
   logic [NUM_CH*BIT_WIDTH-1:0] count;
   logic [NUM_CH-1:0]           at_zero;
   logic [NUM_CH-1:0]           at_max;
   logic [NUM_CH-1:0]           tc_pulse;

   modport master (
      output ch_up, ch_down, ch_load, ch_load_max, ch_wrap, load_val, max_val,
      input  count, at_zero, at_max, tc_pulse
   );

   modport slave (
      input  ch_up, ch_down, ch_load, ch_load_max, ch_wrap, load_val, max_val,
      output count, at_zero, at_max, tc_pulse
   );

endinterface

// File: rtl/multi_channel_timer_channel.sv
// ---------------------------------------------------------------------------
// timer_channel
//   One up/down timer: count, max and terminal-count registers plus their
//   next-state logic.
//   clk, reset (async, active-low)
//   tick              : qualifies up/down (load, load_max, clamping ignore it)
//   up, down          : step requests (both together = hold)
//   load, load_val    : load count, clamped to the effective max
//   load_max, max_val : replace the max register this edge
//   wrap              : 0 = saturate at bounds, 1 = wrap around
//   count, at_zero, at_max, tc_pulse : registered state / decodes
// ---------------------------------------------------------------------------
module timer_channel
   import timer_pkg::*;
#(
   parameter int unsigned BIT_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 up,
   input  logic                 down,
   input  logic                 load,
   input  logic                 load_max,
   input  logic                 wrap,
   input  logic [BIT_WIDTH-1:0] load_val,
   input  logic [BIT_WIDTH-1:0] max_val,
   output logic [BIT_WIDTH-1:0] count,
   output logic                 at_zero,
   output logic                 at_max,
   output logic                 tc_pulse
);

   logic [BIT_WIDTH-1:0] max_reg;
   logic [BIT_WIDTH-1:0] max_eff;
   logic [BIT_WIDTH-1:0] count_nxt;
   logic                 tc_nxt;
   tmr_mode_e            mode;

   assign mode = tmr_mode_e'(wrap);

   // The clamp branch runs before up/down, so every stepping branch below
   // can rely on count <= max_eff.
   always_comb begin
      max_eff   = load_max ? max_val : max_reg;
      count_nxt = count;
      tc_nxt    = 1'b0;
      if (load) begin
         count_nxt = (load_val > max_eff) ? max_eff : load_val;
      end else if (count > max_eff) begin
         count_nxt = max_eff;
      end else if (tick && up && !down) begin
         if (count < max_eff) begin
            count_nxt = count + 1'b1;
            tc_nxt    = (count_nxt == max_eff);
         end else if (mode == TMR_WRAP) begin
            count_nxt = '0;
            tc_nxt    = 1'b1;
         end
      end else if (tick && down && !up) begin
         if (count != '0) begin
            count_nxt = count - 1'b1;
            tc_nxt    = (count_nxt == '0);
         end else if (mode == TMR_WRAP) begin
            count_nxt = max_eff;
            tc_nxt    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         max_reg  <= '1;
         tc_pulse <= 1'b0;
      end else begin
         count    <= count_nxt;
         max_reg  <= max_eff;
         tc_pulse <= tc_nxt;
      end
   end

   assign at_zero = (count == '0);
   assign at_max  = (count == max_reg);

endmodule

// File: rtl/multi_channel_timer.sv
// ---------------------------------------------------------------------------
// multi_channel_timer
//   NUM_CH independent up/down timers with programmable max, load and
//   saturate/wrap mode; one timer per traffic phase, tc_pulse feeds TrafficMode.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : multi_channel_timer_if.slave (requests in, count/status out)
//   Optional feature macro: TIMER_PRESCALE_EN -- a shared prescaler gates
//   ch_up/ch_down to one cycle in PRESCALE.
// ---------------------------------------------------------------------------
module multi_channel_timer
   import timer_pkg::*;
#(
   parameter int unsigned BIT_WIDTH = 5,
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned PRESCALE  = 10
) (
   input logic                  clk,
   input logic                  reset,
   multi_channel_timer_if.slave bus
);

   logic tick;

`ifdef TIMER_PRESCALE_EN
   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_cnt <= '0;
      end else if (pre_cnt == PRE_LAST) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   assign tick = (pre_cnt == PRE_LAST);
`else
   // No prescaler: tick is constant 1 for any legal PRESCALE (>= 1).
   assign tick = (PRESCALE != 0);
`endif

   logic [BIT_WIDTH-1:0] cnt_ch  [NUM_CH];
   logic                 zero_ch [NUM_CH];
   logic                 max_ch  [NUM_CH];
   logic                 tc_ch   [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam int unsigned LO = slice_lo(g, BIT_WIDTH);

      timer_channel #(
         .BIT_WIDTH (BIT_WIDTH)
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .tick     (tick),
         .up       (bus.ch_up[g]),
         .down     (bus.ch_down[g]),
         .load     (bus.ch_load[g]),
         .load_max (bus.ch_load_max[g]),
         .wrap     (bus.ch_wrap[g]),
         .load_val (bus.load_val[LO +: BIT_WIDTH]),
         .max_val  (bus.max_val[LO +: BIT_WIDTH]),
         .count    (cnt_ch[g]),
         .at_zero  (zero_ch[g]),
         .at_max   (max_ch[g]),
         .tc_pulse (tc_ch[g])
      );
   end

   // Per-channel results are gathered here so each bus signal has one driver.
   always_comb begin
      bus.count    = '0;
      bus.at_zero  = '0;
      bus.at_max   = '0;
      bus.tc_pulse = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         bus.count[slice_lo(i, BIT_WIDTH) +: BIT_WIDTH] = cnt_ch[i];
         bus.at_zero[i]  = zero_ch[i];
         bus.at_max[i]   = max_ch[i];
         bus.tc_pulse[i] = tc_ch[i];
      end
   end

endmodule

// File: tb/tb_multi_channel_timer.sv
module tb_multi_channel_timer;

   localparam int BW = 5;
   localparam int NC = 4;
`ifdef TIMER_PRESCALE_EN
   localparam int TB_PRESCALE = 4;
`else
   localparam int TB_PRESCALE = 10;
`endif

   logic clk;
   logic reset;

   multi_channel_timer_if #(.BIT_WIDTH(BW), .NUM_CH(NC)) bus ();

   multi_channel_timer #(
      .BIT_WIDTH (BW),
      .NUM_CH    (NC),
      .PRESCALE  (TB_PRESCALE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Reference model: plain integers per channel
   int m_cnt [NC];
   int m_max [NC];
   bit m_tc  [NC];
   int m_pre;

   function automatic void model_reset();
      for (int i = 0; i < NC; i++) begin
         m_cnt[i] = 0;
         m_max[i] = (1 << BW) - 1;
         m_tc[i]  = 1'b0;
      end
      m_pre = 0;
   endfunction

   // One rising edge of the specified behaviour, from the current inputs.
   function automatic void model_step();
      bit tk;
      if (!reset) begin
         model_reset();
         return;
      end
`ifdef TIMER_PRESCALE_EN
      tk    = (m_pre == TB_PRESCALE - 1);
      m_pre = (m_pre + 1) % TB_PRESCALE;
`else
      tk = 1'b1;
`endif
      for (int i = 0; i < NC; i++) begin
         int lv, mv, mx, c;
         bit tc;
         lv = int'(bus.load_val[i*BW +: BW]);
         mv = int'(bus.max_val[i*BW +: BW]);
         mx = bus.ch_load_max[i] ? mv : m_max[i];
         c  = m_cnt[i];
         tc = 1'b0;
         if (bus.ch_load[i]) c = (lv < mx) ? lv : mx;
         else if (c > mx) c = mx;
         else if (tk && bus.ch_up[i] && !bus.ch_down[i]) begin
            if (c < mx) begin c = c + 1; tc = (c == mx); end
            else if (bus.ch_wrap[i]) begin c = 0; tc = 1'b1; end
         end else if (tk && bus.ch_down[i] && !bus.ch_up[i]) begin
            if (c > 0) begin c = c - 1; tc = (c == 0); end
            else if (bus.ch_wrap[i]) begin c = mx; tc = 1'b1; end
         end
         m_cnt[i] = c;
         m_max[i] = mx;
         m_tc[i]  = tc;
      end
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   function automatic int cnt_of(input int i);
      return int'(bus.count[i*BW +: BW]);
   endfunction

   task automatic idle();
      bus.ch_up       = '0;
      bus.ch_down     = '0;
      bus.ch_load     = '0;
      bus.ch_load_max = '0;
      bus.ch_wrap     = '0;
   endtask

   task automatic set_lv(input int i, input int v);
      bus.load_val[i*BW +: BW] = BW'(v);
   endtask

   task automatic set_mv(input int i, input int v);
      bus.max_val[i*BW +: BW] = BW'(v);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle();
      bus.load_val = '0;
      bus.max_val  = '0;
      repeat (3) cycle();
      reset = 1'b1;
      for (int i = 0; i < NC; i++) begin
         checks++;
         if (bus.count[i*BW +: BW] !== '0 || bus.at_zero[i] !== 1'b1 ||
             bus.at_max[i] !== 1'b0 || bus.tc_pulse[i] !== 1'b0)
            $display("FAIL reset_state ch%0d: count=%0d z=%b m=%b tc=%b, want 0 1 0 0",
                     i, cnt_of(i), bus.at_zero[i], bus.at_max[i], bus.tc_pulse[i]);
         else passed++;
      end
      // ch0 to 17, then assert reset mid-low-phase with requests pending
      set_lv(0, 17); bus.ch_load[0] = 1'b1;
      cycle();
      bus.ch_load[0] = 1'b0; bus.ch_up = '1;
      checks++;
      if (cnt_of(0) !== 17) $display("FAIL reset_preload: count=%0d want 17", cnt_of(0));
      else passed++;
      #2 reset = 1'b0;
      #1;
      checks++;
      if (cnt_of(0) !== 0 || bus.at_zero[0] !== 1'b1 || bus.at_max[0] !== 1'b0 ||
          bus.tc_pulse[0] !== 1'b0)
         $display("FAIL async_reset: count=%0d z=%b m=%b tc=%b, want 0 1 0 0",
                  cnt_of(0), bus.at_zero[0], bus.at_max[0], bus.tc_pulse[0]);
      else passed++;
      idle();
      @(negedge clk);
      cycle();
      reset = 1'b1;
      // max reset value 31: loading 31 lands exactly on max
      set_lv(0, 31); bus.ch_load[0] = 1'b1;
      cycle();
      idle();
      checks++;
      if (cnt_of(0) !== 31 || bus.at_max[0] !== 1'b1 || bus.tc_pulse[0] !== 1'b0)
         $display("FAIL reset_max: count=%0d at_max=%b tc=%b, want 31 1 0",
                  cnt_of(0), bus.at_max[0], bus.tc_pulse[0]);
      else passed++;
      reset = 1'b0;
      cycle();
      reset = 1'b1;
   endtask

   task automatic test_sat_up();
      int tcs = 0;
      set_mv(0, 20); bus.ch_load_max[0] = 1'b1; bus.ch_up[0] = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         int exp_c;
         cycle();
         bus.ch_load_max[0] = 1'b0;
         exp_c = (k < 20) ? k : 20;
         if (bus.tc_pulse[0]) tcs++;
         checks++;
         if (cnt_of(0) !== exp_c || bus.tc_pulse[0] !== (k == 20))
            $display("FAIL sat_up step%0d: count=%0d tc=%b want %0d %b",
                     k, cnt_of(0), bus.tc_pulse[0], exp_c, (k == 20));
         else passed++;
      end
      idle();
      checks++;
      if (tcs != 1 || bus.at_max[0] !== 1'b1)
         $display("FAIL sat_up_final: tc_count=%0d at_max=%b want 1 1", tcs, bus.at_max[0]);
      else passed++;
   endtask

   task automatic test_wrap_down();
      set_lv(1, 15); bus.ch_load[1] = 1'b1;
      cycle();
      bus.ch_load[1] = 1'b0;
      checks++;
      if (cnt_of(1) !== 15 || bus.tc_pulse[1] !== 1'b0)
         $display("FAIL wrap_load: count=%0d tc=%b want 15 0", cnt_of(1), bus.tc_pulse[1]);
      else passed++;
      bus.ch_down[1] = 1'b1; bus.ch_wrap[1] = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         int exp_c;
         bit exp_tc;
         cycle();
         exp_c  = (k <= 15) ? 15 - k : ((k == 16) ? 31 : 30);
         exp_tc = (k == 15) || (k == 16);
         checks++;
         if (cnt_of(1) !== exp_c || bus.tc_pulse[1] !== exp_tc)
            $display("FAIL wrap_down step%0d: count=%0d tc=%b want %0d %b",
                     k, cnt_of(1), bus.tc_pulse[1], exp_c, exp_tc);
         else passed++;
      end
      idle();
      checks++;
      if (cnt_of(2) !== 0 || cnt_of(3) !== 0 || cnt_of(0) !== 20)
         $display("FAIL wrap_isolation: ch0=%0d ch2=%0d ch3=%0d want 20 0 0",
                  cnt_of(0), cnt_of(2), cnt_of(3));
      else passed++;
   endtask

   task automatic test_max_clamp();
      set_lv(2, 25); bus.ch_load[2] = 1'b1;
      cycle();
      bus.ch_load[2] = 1'b0;
      checks++;
      if (cnt_of(2) !== 25) $display("FAIL clamp_load: count=%0d want 25", cnt_of(2));
      else passed++;
      set_mv(2, 10); bus.ch_load_max[2] = 1'b1;
      cycle();
      bus.ch_load_max[2] = 1'b0;
      checks++;
      if (cnt_of(2) !== 10 || bus.tc_pulse[2] !== 1'b0 || bus.at_max[2] !== 1'b1)
         $display("FAIL clamp_max: count=%0d tc=%b at_max=%b want 10 0 1",
                  cnt_of(2), bus.tc_pulse[2], bus.at_max[2]);
      else passed++;
      set_lv(2, 28); bus.ch_load[2] = 1'b1;
      cycle();
      idle();
      checks++;
      if (cnt_of(2) !== 10 || bus.tc_pulse[2] !== 1'b0 || bus.at_max[2] !== 1'b1)
         $display("FAIL clamp_loadval: count=%0d tc=%b at_max=%b want 10 0 1",
                  cnt_of(2), bus.tc_pulse[2], bus.at_max[2]);
      else passed++;
   endtask

   task automatic test_priority();
      set_lv(3, 7); bus.ch_load[3] = 1'b1;
      cycle();
      bus.ch_load[3] = 1'b0;
      bus.ch_up[3] = 1'b1; bus.ch_down[3] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         checks++;
         if (cnt_of(3) !== 7 || bus.tc_pulse[3] !== 1'b0)
            $display("FAIL updown_hold step%0d: count=%0d tc=%b want 7 0",
                     k, cnt_of(3), bus.tc_pulse[3]);
         else passed++;
      end
      bus.ch_down[3] = 1'b0;
      set_lv(3, 3); bus.ch_load[3] = 1'b1;
      cycle();
      idle();
      checks++;
      if (cnt_of(3) !== 3 || bus.tc_pulse[3] !== 1'b0)
         $display("FAIL load_over_up: count=%0d tc=%b want 3 0", cnt_of(3), bus.tc_pulse[3]);
      else passed++;
   endtask

`ifdef TIMER_PRESCALE_EN
   task automatic test_prescale();
      idle();
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      bus.ch_up[0] = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         cycle();
         checks++;
         if (cnt_of(0) !== k / 4 || cnt_of(0) !== m_cnt[0])
            $display("FAIL prescale edge%0d: count=%0d want %0d", k, cnt_of(0), k / 4);
         else passed++;
      end
      idle();
   endtask
`endif

   task automatic test_random();
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < NC; i++) begin
            bus.ch_up[i]       = $urandom_range(0, 1) == 1;
            bus.ch_down[i]     = $urandom_range(0, 2) == 0;
            bus.ch_load[i]     = $urandom_range(0, 9) == 0;
            bus.ch_load_max[i] = $urandom_range(0, 11) == 0;
            bus.ch_wrap[i]     = $urandom_range(0, 1) == 1;
            set_lv(i, $urandom_range(0, 31));
            set_mv(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31));
         end
         cycle();
         for (int i = 0; i < NC; i++) begin
            checks++;
            if (cnt_of(i) !== m_cnt[i] || bus.tc_pulse[i] !== m_tc[i] ||
                bus.at_zero[i] !== (m_cnt[i] == 0) || bus.at_max[i] !== (m_cnt[i] == m_max[i]))
               $display("FAIL random cyc%0d ch%0d: count=%0d tc=%b z=%b m=%b want %0d %b %b %b",
                        cyc, i, cnt_of(i), bus.tc_pulse[i], bus.at_zero[i], bus.at_max[i],
                        m_cnt[i], m_tc[i], (m_cnt[i] == 0), (m_cnt[i] == m_max[i]));
            else passed++;
         end
      end
      idle();
   endtask

   initial begin
      reset = 1'b0;
      idle();
      bus.load_val = '0;
      bus.max_val  = '0;
      model_reset();
      @(negedge clk);
      test_reset();
`ifdef TIMER_PRESCALE_EN
      test_prescale();
`else
      test_sat_up();
      test_wrap_down();
      test_max_clamp();
      test_priority();
`endif
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
